bm_dag3_result_acc: RTL

//  Downstream stage of the dag3 benchmark top. Consumes its 2-bit sum result (out0) and 1-bit

---
 rtl/bm_dag3_result_acc.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/bm_dag3_result_acc.sv
// Windowed accumulator for the dag3 sum/difference stream. The result is held behind a
// valid/ready handshake. Optional saturation is built when BM_DAG3_ACC_SAT_EN is defined.
module bm_dag3_result_acc #(
  parameter int BITS   = 2,
  parameter int WINDOW = 4,
  parameter int ACC_W  = 8,
  parameter int CNT_W  = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [BITS-1:0]  a_sum,
  input  logic             a_bit,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] sum_out,
  output logic [CNT_W-1:0] ones_out,
  output logic             sat
);

  typedef enum logic [1:0] {S_IDLE, S_ACC, S_HOLD} state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WINDOW - 1);

  state_t            state_reg, state_next;
  logic [ACC_W-1:0]  acc_reg, acc_next;
  logic [CNT_W-1:0]  ones_reg, ones_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic              out_valid_reg, out_valid_next;
  logic [ACC_W-1:0]  sum_out_reg, sum_out_next;
  logic [CNT_W-1:0]  ones_out_reg, ones_out_next;
  logic [ACC_W-1:0]  a_ext;
  logic [ACC_W-1:0]  add_val;
  logic              accept;
  logic              win_start;
  logic              win_step;
  logic              win_done;

  assign a_ext     = ACC_W'(a_sum);
  assign in_ready  = (state_reg != S_HOLD);
  assign accept    = in_valid & in_ready;
  assign out_valid = out_valid_reg;
  assign sum_out   = sum_out_reg;
  assign ones_out  = ones_out_reg;

`ifdef BM_DAG3_ACC_SAT_EN
  logic [ACC_W:0] sum_full;
  logic           ovf;
  logic           flag_reg;
  logic           sat_reg;

  assign sum_full = {1'b0, acc_reg} + {1'b0, a_ext};
  assign ovf      = sum_full[ACC_W];
  assign add_val  = ovf ? {ACC_W{1'b1}} : sum_full[ACC_W-1:0];
  assign sat      = sat_reg;

  // Sticky clamp flag lives for one window; the first sample alone can never clamp.
  always_ff @(posedge clock) begin
    if (reset) begin
      flag_reg <= 1'b0;
      sat_reg  <= 1'b0;
    end else begin
      if (win_start)
        flag_reg <= 1'b0;
      else if (win_step)
        flag_reg <= flag_reg | ovf;
      if (win_done)
        sat_reg <= win_start ? 1'b0 : (flag_reg | ovf);
    end
  end
`else
  assign add_val = acc_reg + a_ext;
  assign sat     = 1'b0;
`endif

  always_comb begin
    state_next     = state_reg;
    acc_next       = acc_reg;
    ones_next      = ones_reg;
    cnt_next       = cnt_reg;
    out_valid_next = out_valid_reg;
    sum_out_next   = sum_out_reg;
    ones_out_next  = ones_out_reg;
    win_start      = 1'b0;
    win_step       = 1'b0;
    win_done       = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (accept) begin
          win_start = 1'b1;
          acc_next  = a_ext;
          ones_next = CNT_W'(a_bit);
          cnt_next  = CNT_W'(1);
          if (WINDOW == 1) begin
            win_done       = 1'b1;
            out_valid_next = 1'b1;
            sum_out_next   = a_ext;
            ones_out_next  = CNT_W'(a_bit);
            state_next     = S_HOLD;
          end else begin
            state_next = S_ACC;
          end
        end
      end
      S_ACC: begin
        if (accept) begin
          win_step  = 1'b1;
          acc_next  = add_val;
          ones_next = ones_reg + CNT_W'(a_bit);
          cnt_next  = cnt_reg + CNT_W'(1);
          if (cnt_reg == LAST_CNT) begin
            win_done       = 1'b1;
            out_valid_next = 1'b1;
            sum_out_next   = add_val;
            ones_out_next  = ones_reg + CNT_W'(a_bit);
            state_next     = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (out_ready) begin
          out_valid_next = 1'b0;
          acc_next       = '0;
          ones_next      = '0;
          cnt_next       = '0;
          state_next     = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg     <= S_IDLE;
      acc_reg       <= '0;
      ones_reg      <= '0;
      cnt_reg       <= '0;
      out_valid_reg <= 1'b0;
      sum_out_reg   <= '0;
      ones_out_reg  <= '0;
    end else begin
      state_reg     <= state_next;
      acc_reg       <= acc_next;
      ones_reg      <= ones_next;
      cnt_reg       <= cnt_next;
      out_valid_reg <= out_valid_next;
      sum_out_reg   <= sum_out_next;
      ones_out_reg  <= ones_out_next;
    end
  end

endmodule
